vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/sync_fall_det.sv | 23 ++
 rtl/vga_sync_decoder.sv | 147 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants and decoder state encoding.
// Shared by the sync decoder and its edge detectors.
package vga_timing_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;

  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } vga_state_e;

endpackage

// File: rtl/sync_fall_det.sv
// Registers an active-low sync line when enabled and flags its
// falling edge in the same enabled cycle.
module sync_fall_det (
  input  logic clk_50,
  input  logic reset,
  input  logic en,
  input  logic sync_n,
  output logic fall
);

  logic q;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      q <= 1'b1;
    end else if (en) begin
      q <= sync_n;
    end
  end

  assign fall = en & ~sync_n & q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a VGA HS/VS stream.
// Locks after one clean frame; any line/frame length error drops lock.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC_N = H_SYNC,
  parameter int H_BP_N   = H_BP,
  parameter int H_ACT_N  = H_ACTIVE,
  parameter int H_FP_N   = H_FP,
  parameter int V_SYNC_N = V_SYNC,
  parameter int V_BP_N   = V_BP,
  parameter int V_ACT_N  = V_ACTIVE,
  parameter int V_FP_N   = V_FP
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [11:0] pixel_color_in,
  output logic [9:0]  X_pix,
  output logic [9:0]  Y_pix,
  output logic        pix_valid,
  output logic [11:0] pix_color,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err
);

  localparam int H_TOT_N = H_SYNC_N + H_BP_N + H_ACT_N + H_FP_N;
  localparam int V_TOT_N = V_SYNC_N + V_BP_N + V_ACT_N + V_FP_N;

  localparam logic [9:0] H_LAST = 10'(H_TOT_N - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT_N - 1);
  localparam logic [9:0] H_LO   = 10'(H_SYNC_N + H_BP_N);
  localparam logic [9:0] H_HI   = 10'(H_SYNC_N + H_BP_N + H_ACT_N - 1);
  localparam logic [9:0] V_LO   = 10'(V_SYNC_N + V_BP_N);
  localparam logic [9:0] V_HI   = 10'(V_SYNC_N + V_BP_N + V_ACT_N - 1);

  logic       hs_fall;
  logic       vs_fall;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_err_c;
  logic       v_err_c;
  logic       any_err;
  logic       in_win;

  vga_state_e state;
  vga_state_e state_nxt;

  sync_fall_det u_hs (
    .clk_50 (clk_50),
    .reset  (reset),
    .en     (pixel_en),
    .sync_n (VGA_HS),
    .fall   (hs_fall)
  );

  // VS is only meaningful at line starts, so it is sampled on HS edges
  sync_fall_det u_vs (
    .clk_50 (clk_50),
    .reset  (reset),
    .en     (hs_fall),
    .sync_n (VGA_VS),
    .fall   (vs_fall)
  );

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (hs_fall) begin
      h_nxt = '0;
    end else if (pixel_en && h_cnt != '1) begin
      h_nxt = h_cnt + 10'd1;
    end
    if (vs_fall) begin
      v_nxt = '0;
    end else if (hs_fall && v_cnt != '1) begin
      v_nxt = v_cnt + 10'd1;
    end
    h_err_c = hs_fall && h_cnt != H_LAST
              && state != SEARCH;
    v_err_c = (vs_fall && v_cnt != V_LAST
               && state == LOCKED)
           || (hs_fall && !vs_fall && v_cnt == V_LAST
               && state != SEARCH);
    any_err = h_err_c || v_err_c;
    in_win  = pixel_en && state == LOCKED
              && h_nxt >= H_LO && h_nxt <= H_HI
              && v_nxt >= V_LO && v_nxt <= V_HI;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      any_err:
        state_nxt = SEARCH;
      !any_err && vs_fall && state == SEARCH:
        state_nxt = CHECK;
      !any_err && vs_fall && state == CHECK && v_cnt == V_LAST:
        state_nxt = LOCKED;
      default:
        state_nxt = state;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      X_pix       <= '0;
      Y_pix       <= '0;
      pix_color   <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pix_valid   <= in_win;
      frame_start <= vs_fall;
      locked      <= (state_nxt == LOCKED);
      h_err       <= h_err_c;
      v_err       <= v_err_c;
      if (in_win) begin
        X_pix     <= h_nxt - H_LO;
        Y_pix     <= v_nxt - V_LO;
        pix_color <= pixel_color_in;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives scaled-down VGA frames with random colour and checks the
// decoder against a frame-level reference model.
module tb_vga_sync_decoder;

  localparam int HSY = 8;
  localparam int HBP = 6;
  localparam int HAC = 32;
  localparam int HFP = 4;
  localparam int HT  = HSY + HBP + HAC + HFP;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int VAC = 6;
  localparam int VFP = 2;
  localparam int VT  = VSY + VBP + VAC + VFP;
  localparam int HLO = HSY + HBP;
  localparam int VLO = VSY + VBP;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_en = 1'b0;
  logic        VGA_HS = 1'b1;
  logic        VGA_VS = 1'b1;
  logic [11:0] pixel_color_in = '0;
  logic [9:0]  X_pix;
  logic [9:0]  Y_pix;
  logic        pix_valid;
  logic [11:0] pix_color;
  logic        frame_start;
  logic        locked;
  logic        h_err;
  logic        v_err;

  always #5 clk_50 = ~clk_50;

  vga_sync_decoder #(
    .H_SYNC_N (HSY),
    .H_BP_N   (HBP),
    .H_ACT_N  (HAC),
    .H_FP_N   (HFP),
    .V_SYNC_N (VSY),
    .V_BP_N   (VBP),
    .V_ACT_N  (VAC),
    .V_FP_N   (VFP)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .pixel_en       (pixel_en),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .pixel_color_in (pixel_color_in),
    .X_pix          (X_pix),
    .Y_pix          (Y_pix),
    .pix_valid      (pix_valid),
    .pix_color      (pix_color),
    .frame_start    (frame_start),
    .locked         (locked),
    .h_err          (h_err),
    .v_err          (v_err)
  );

  int n_tests = 0;
  int n_fail = 0;

  // model: 0 searching, 1 checking, 2 locked
  int          st;
  bit          m_hsq;
  bit          m_vsq;
  int          m_plen;
  int          m_row;
  int          ex;
  int          ey;
  logic [11:0] ec;
  bit          ev;
  bit          efs;
  bit          ehe;
  bit          eve;

  int pcount;
  int fx;
  int fy;
  int lx;
  int ly;
  bit saw_valid;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string w);
    chk({w, ".pix_valid"}, 32'(pix_valid), 32'(ev));
    chk({w, ".frame_start"}, 32'(frame_start), 32'(efs));
    chk({w, ".locked"}, 32'(locked), 32'(st == 2));
    chk({w, ".h_err"}, 32'(h_err), 32'(ehe));
    chk({w, ".v_err"}, 32'(v_err), 32'(eve));
    chk({w, ".X_pix"}, 32'(X_pix), 32'(ex));
    chk({w, ".Y_pix"}, 32'(Y_pix), 32'(ey));
    chk({w, ".pix_color"}, 32'(pix_color), 32'(ec));
  endtask

  task automatic model_reset();
    st = 0;
    m_hsq = 1'b1;
    m_vsq = 1'b1;
    m_plen = 1;
    m_row = 0;
    ex = 0;
    ey = 0;
    ec = '0;
    ev = 1'b0;
    efs = 1'b0;
    ehe = 1'b0;
    eve = 1'b0;
  endtask

  // p/l are the generator's own pixel and line positions
  task automatic model_sample(input bit hs, input bit vs,
                              input logic [11:0] c,
                              input int p, input int l);
    bit hsf;
    bit vsf;
    hsf = !hs && m_hsq;
    m_hsq = hs;
    vsf = hsf && !vs && m_vsq;
    if (hsf) m_vsq = vs;
    ehe = hsf && st != 0 && m_plen != HT;
    eve = (vsf && st == 2 && m_row != VT - 1)
       || (hsf && !vsf && st != 0 && m_row == VT - 1);
    efs = vsf;
    if (ehe || eve) begin
      st = 0;
    end else if (vsf) begin
      if (st == 0) st = 1;
      else if (st == 1 && m_row == VT - 1) st = 2;
    end
    m_plen = hsf ? 1 : m_plen + 1;
    if (vsf) m_row = 0;
    else if (hsf && m_row < 1023) m_row++;
    ev = st == 2 && p >= HLO && p < HLO + HAC
         && l >= VLO && l < VLO + VAC;
    if (ev) begin
      ex = p - HLO;
      ey = l - VLO;
      ec = c;
    end
  endtask

  task automatic px(input bit hs, input bit vs,
                    input logic [11:0] c,
                    input int p, input int l);
    pixel_en = 1'b1;
    VGA_HS = hs;
    VGA_VS = vs;
    pixel_color_in = c;
    model_sample(hs, vs, c, p, l);
    @(posedge clk_50);
    #1;
    pixel_en = 1'b0;
    check_outs("smp");
    saw_valid = (pix_valid === 1'b1);
    if (saw_valid) begin
      if (pcount == 0) begin
        fx = int'(X_pix);
        fy = int'(Y_pix);
      end
      lx = int'(X_pix);
      ly = int'(Y_pix);
      pcount++;
    end
    ev = 1'b0;
    efs = 1'b0;
    ehe = 1'b0;
    eve = 1'b0;
    @(posedge clk_50);
    #1;
    check_outs("gap");
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outs("rst");
    @(posedge clk_50);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50);
      #1;
      check_outs("idle");
    end
  endtask

  task automatic frame(input int nl, input int short_l,
                       input int rst_l, input int idle_l,
                       input bit tgt);
    bit          full;
    bit          hit;
    int          len;
    logic [11:0] c;
    pcount = 0;
    full = 1'b0;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        hit = tgt && p == HLO + 20 && l == VLO + 3;
        c = hit ? 12'hF00 : 12'($urandom);
        px(p >= HSY, l >= VSY, c, p, l);
        if (hit) begin
          chk("tgt.valid", 32'(saw_valid), 32'd1);
          chk("tgt.X", 32'(X_pix), 32'd20);
          chk("tgt.Y", 32'(Y_pix), 32'd3);
          chk("tgt.color", 32'(pix_color), 32'hF00);
        end
        if (l == 0 && p == 0) begin
          full = st == 2 && nl == VT && short_l < 0 && rst_l < 0;
        end
        if (l == rst_l && p == HLO + 5) do_reset();
        if (l == idle_l && p == HLO + 3) idle(1000);
      end
    end
    if (full) begin
      chk("frm.count", 32'(pcount), 32'(HAC * VAC));
      chk("frm.firstX", 32'(fx), 32'd0);
      chk("frm.firstY", 32'(fy), 32'd0);
      chk("frm.lastX", 32'(lx), 32'(HAC - 1));
      chk("frm.lastY", 32'(ly), 32'(VAC - 1));
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    @(posedge clk_50);
    #1;
    check_outs("por");
    reset = 1'b0;

    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b1);

    frame(VT, 7, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);

    frame(VT - 1, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);

    frame(VT + 2, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);

    frame(VT, -1, -1, 6, 1'b0);
    frame(VT, -1, 6, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);
    frame(VT, -1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
